// File: rtl/obs_capture_pkg.sv
// Shared state encoding and record layout for the obs_capture change logger.
package obs_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int VAL_W  = 3;
  localparam int TS_LSB = 0;

  // Record layout: {wrap, qval, udp_out, muxout, ts}
  function automatic int rec_w(input int ts_w);
    return ts_w + VAL_W + 1;
  endfunction

  function automatic int wrap_bit(input int ts_w);
    return ts_w + VAL_W;
  endfunction

  function automatic int val_msb(input int ts_w);
    return ts_w + VAL_W - 1;
  endfunction

  function automatic int val_lsb(input int ts_w);
    return ts_w;
  endfunction

  function automatic int ts_msb(input int ts_w);
    return ts_w - 1;
  endfunction

endpackage

// File: rtl/obs_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is the oldest entry, zero when empty.
module obs_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/obs_capture.sv
// Samples qval/udp_out/muxout each cycle and logs timestamped changes into a FIFO
// drained over a valid/ready port.
module obs_capture
  import obs_capture_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TS_W   = 12,
  parameter int DROP_W = 8
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     qval,
  input  logic                     udp_out,
  input  logic                     muxout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [rec_w(TS_W)-1:0]   out_data,
  output logic                     busy,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int REC_W    = rec_w(TS_W);
  localparam int WRAP_BIT = wrap_bit(TS_W);
  localparam int VAL_MSB  = val_msb(TS_W);
  localparam int VAL_LSB  = val_lsb(TS_W);
  localparam int TS_MSB   = ts_msb(TS_W);

  state_t            state_reg, state_next;
  logic [VAL_W-1:0]  smp_reg;
  logic [VAL_W-1:0]  last_reg, last_next;
  logic [TS_W-1:0]   ts_reg, ts_next;
  logic              overflow_reg;
  logic [DROP_W-1:0] drop_reg;

  logic              push, pop, drop;
  logic              fifo_full, fifo_empty;
  logic              rec_wrap;
  logic [VAL_W-1:0]  rec_val;
  logic [TS_W-1:0]   rec_ts;
  logic [REC_W-1:0]  push_data;

  always_comb begin
    state_next = state_reg;
    ts_next    = ts_reg;
    last_next  = last_reg;
    push       = 1'b0;
    rec_wrap   = 1'b0;
    rec_val    = smp_reg;
    rec_ts     = ts_reg;
    case (state_reg)
      IDLE: if (start) state_next = PRIME;
      PRIME: begin
        push       = 1'b1;
        rec_ts     = '0;
        ts_next    = '0;
        last_next  = smp_reg;
        state_next = RUN;
      end
      RUN: begin
        if (stop) begin
          state_next = DRAIN;
        end else if (&ts_reg) begin
          // Wrap wins; last is held so a coincident change is logged next cycle.
          push     = 1'b1;
          rec_wrap = 1'b1;
          rec_val  = last_reg;
          ts_next  = '0;
        end else begin
          ts_next = ts_reg + 1'b1;
          if (smp_reg != last_reg) begin
            push      = 1'b1;
            last_next = smp_reg;
          end
        end
      end
      DRAIN: if (fifo_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    push_data                  = '0;
    push_data[WRAP_BIT]        = rec_wrap;
    push_data[VAL_MSB:VAL_LSB] = rec_val;
    push_data[TS_MSB:TS_LSB]   = rec_ts;
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = push && fifo_full && !pop;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg    <= IDLE;
      smp_reg      <= '0;
      last_reg     <= '0;
      ts_reg       <= '0;
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
    end else begin
      state_reg <= state_next;
      smp_reg   <= {qval, udp_out, muxout};
      last_reg  <= last_next;
      ts_reg    <= ts_next;
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_reg != '1) drop_reg <= drop_reg + 1'b1;
      end
    end
  end

  obs_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_data)
  );

  assign busy       = (state_reg != IDLE);
  assign overflow   = overflow_reg;
  assign drop_count = drop_reg;

endmodule

// File: tb/tb_obs_capture.sv
// Bench for obs_capture: two instances (12-bit/8-deep and 4-bit/4-deep) against a
// queue-based change-log model, plus directed table and corner sequences.
module tb_obs_capture;

  logic clock = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0, stop = 1'b0;
  logic qval = 1'b0, udp_out = 1'b0, muxout = 1'b0, out_ready = 1'b0;

  logic        out_valid_a, busy_a, overflow_a;
  logic [15:0] out_data_a;
  logic [7:0]  drop_count_a;
  logic        out_valid_b, busy_b, overflow_b;
  logic [7:0]  out_data_b;
  logic [2:0]  drop_count_b;

  obs_capture #(.DEPTH(8), .TS_W(12), .DROP_W(8)) dut_a (
    .clock(clock), .clear(clear), .start(start), .stop(stop),
    .qval(qval), .udp_out(udp_out), .muxout(muxout),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .busy(busy_a), .overflow(overflow_a), .drop_count(drop_count_a)
  );

  obs_capture #(.DEPTH(4), .TS_W(4), .DROP_W(3)) dut_b (
    .clock(clock), .clear(clear), .start(start), .stop(stop),
    .qval(qval), .udp_out(udp_out), .muxout(muxout),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .busy(busy_b), .overflow(overflow_b), .drop_count(drop_count_b)
  );

  always #5 clock = ~clock;

  // Reference model: activity phase, timestamp, and a record list per instance.
  localparam int WAITING = 0, ARMING = 1, CAPTURING = 2, FLUSHING = 3;
  int p_depth   [2] = '{8, 4};
  int p_tsw     [2] = '{12, 4};
  int p_dropmax [2] = '{255, 7};
  int m_phase [2];
  int m_ts    [2];
  int m_last  [2];
  int m_smp   [2];
  int m_drops [2];
  int m_cnt   [2];
  int m_ovf   [2];
  int m_list  [2][8];

  int n_chk = 0;
  int n_err = 0;

  function automatic int pack(input int m, input int w, input int v, input int t);
    return (w << (p_tsw[m] + 3)) | (v << p_tsw[m]) | t;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_phase[m] = WAITING; m_ts[m] = 0; m_last[m] = 0; m_smp[m] = 0;
      m_drops[m] = 0; m_cnt[m] = 0; m_ovf[m] = 0;
    end
  endtask

  task automatic model_step(input int m);
    int rec, tsmax;
    bit want, take, lost;
    tsmax = (1 << p_tsw[m]) - 1;
    want  = 1'b0;
    rec   = 0;
    take  = (m_cnt[m] > 0) && out_ready;
    case (m_phase[m])
      WAITING: if (start) m_phase[m] = ARMING;
      ARMING: begin
        rec = pack(m, 0, m_smp[m], 0); want = 1'b1;
        m_ts[m] = 0; m_last[m] = m_smp[m]; m_phase[m] = CAPTURING;
      end
      CAPTURING: begin
        if (stop) m_phase[m] = FLUSHING;
        else if (m_ts[m] == tsmax) begin
          rec = pack(m, 1, m_last[m], tsmax); want = 1'b1; m_ts[m] = 0;
        end else begin
          if (m_smp[m] != m_last[m]) begin
            rec = pack(m, 0, m_smp[m], m_ts[m]); want = 1'b1; m_last[m] = m_smp[m];
          end
          m_ts[m] = m_ts[m] + 1;
        end
      end
      FLUSHING: if (m_cnt[m] == 0) m_phase[m] = WAITING;
      default: ;
    endcase
    lost = want && (m_cnt[m] == p_depth[m]) && !take;
    if (take) begin
      for (int i = 0; i < 7; i++) m_list[m][i] = m_list[m][i+1];
      m_cnt[m] = m_cnt[m] - 1;
    end
    if (want && !lost) begin
      m_list[m][m_cnt[m]] = rec;
      m_cnt[m] = m_cnt[m] + 1;
    end
    if (lost) begin
      m_ovf[m] = 1;
      if (m_drops[m] < p_dropmax[m]) m_drops[m] = m_drops[m] + 1;
    end
    m_smp[m] = 32'({qval, udp_out, muxout});
  endtask

  function automatic int exp_data(input int m);
    return (m_cnt[m] > 0) ? m_list[m][0] : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("a.out_valid",  32'(out_valid_a),  32'(m_cnt[0] > 0));
    chk("a.out_data",   32'(out_data_a),   exp_data(0));
    chk("a.busy",       32'(busy_a),       32'(m_phase[0] != WAITING));
    chk("a.overflow",   32'(overflow_a),   m_ovf[0]);
    chk("a.drop_count", 32'(drop_count_a), m_drops[0]);
    chk("b.out_valid",  32'(out_valid_b),  32'(m_cnt[1] > 0));
    chk("b.out_data",   32'(out_data_b),   exp_data(1));
    chk("b.busy",       32'(busy_b),       32'(m_phase[1] != WAITING));
    chk("b.overflow",   32'(overflow_b),   m_ovf[1]);
    chk("b.drop_count", 32'(drop_count_b), m_drops[1]);
  endtask

  task automatic tick();
    @(posedge clock);
    if (!clear) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    @(negedge clock);
    check_all();
  endtask

  typedef struct packed {
    logic        start;
    logic        stop;
    logic [2:0]  val;
    logic        ready;
    logic        e_valid;
    logic [15:0] e_data;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic p, input logic [2:0] v, input logic r,
                              input logic ev, input logic [15:0] ed, input logic eb);
    vec_t x;
    x.start = s; x.stop = p; x.val = v; x.ready = r;
    x.e_valid = ev; x.e_data = ed; x.e_busy = eb;
    return x;
  endfunction

  vec_t vecs [17];

  initial begin
    // Baseline, single change, simultaneous change, stop/start collisions (instance a).
    vecs[ 0] = mk(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b1);
    vecs[ 1] = mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 16'h0000, 1'b1);
    vecs[ 2] = mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 16'h0000, 1'b1);
    vecs[ 3] = mk(1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 16'h0000, 1'b1);
    vecs[ 4] = mk(1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 16'h4002, 1'b1);
    vecs[ 5] = mk(1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 16'h0000, 1'b1);
    vecs[ 6] = mk(1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 16'h0000, 1'b1);
    vecs[ 7] = mk(1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 16'h7005, 1'b1);
    vecs[ 8] = mk(1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 16'h7005, 1'b1);
    vecs[ 9] = mk(1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 16'h0000, 1'b1);
    vecs[10] = mk(1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 16'h0000, 1'b1);
    vecs[11] = mk(1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 16'h0000, 1'b0);
    vecs[12] = mk(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0000, 1'b1);
    vecs[13] = mk(1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 16'h7000, 1'b1);
    vecs[14] = mk(1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 16'h7000, 1'b1);
    vecs[15] = mk(1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 16'h0000, 1'b1);
    vecs[16] = mk(1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 16'h0000, 1'b0);

    model_reset();
    repeat (2) @(negedge clock);
    chk("rst.out_valid",  32'(out_valid_a),  0);
    chk("rst.out_data",   32'(out_data_a),   0);
    chk("rst.busy",       32'(busy_a),       0);
    chk("rst.overflow",   32'(overflow_a),   0);
    chk("rst.drop_count", 32'(drop_count_a), 0);
    chk("rst.b_busy",     32'(busy_b),       0);
    clear = 1'b1;

    for (int i = 0; i < 17; i++) begin
      start = vecs[i].start;
      stop  = vecs[i].stop;
      {qval, udp_out, muxout} = vecs[i].val;
      out_ready = vecs[i].ready;
      tick();
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid_a), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.out_data", i),  32'(out_data_a),  32'(vecs[i].e_data));
      chk($sformatf("vec%0d.busy", i),      32'(busy_a),      32'(vecs[i].e_busy));
    end
    start = 1'b0; stop = 1'b0;

    // Overflow under backpressure: baseline + 12 changes into 8 entries.
    {qval, udp_out, muxout} = 3'b000; out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0; tick();
    for (int k = 0; k < 12; k++) begin
      muxout = ~muxout; tick(); tick();
    end
    chk("ovf.out_valid",  32'(out_valid_a),  1);
    chk("ovf.overflow",   32'(overflow_a),   1);
    chk("ovf.drop_count", 32'(drop_count_a), 5);
    chk("ovf.head",       32'(out_data_a),   32'h0000);

    // Push into a full FIFO in the same cycle as a pop is accepted.
    muxout = ~muxout; tick();
    out_ready = 1'b1; tick();
    chk("fullpop.drop_count", 32'(drop_count_a), 5);
    chk("fullpop.head",       32'(out_data_a),   32'h1001);
    repeat (10) tick();
    chk("drain.out_valid", 32'(out_valid_a), 0);

    // Stop with three records queued.
    out_ready = 1'b0;
    repeat (3) begin
      muxout = ~muxout; tick(); tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop.busy",      32'(busy_a),      1);
    chk("stop.out_valid", 32'(out_valid_a), 1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stop.pop%0d_busy", k), 32'(busy_a), 1);
    end
    chk("stop.emptied", 32'(out_valid_a), 0);
    tick();
    chk("stop.idle", 32'(busy_a), 0);

    // Timestamp wrap on the 4-bit instance.
    {qval, udp_out, muxout} = 3'b101;
    repeat (6) tick();
    start = 1'b1; tick(); start = 1'b0; tick();
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 15) chk("wrap.before", 32'(out_valid_b), 0);
      if (n == 16) begin
        chk("wrap.valid",  32'(out_valid_b), 1);
        chk("wrap.record", 32'(out_data_b),  32'h00DF);
      end
      if (n == 17) chk("wrap.popped", 32'(out_valid_b), 0);
    end

    // Asynchronous clear in the middle of DRAIN.
    out_ready = 1'b0;
    repeat (3) begin
      muxout = ~muxout; tick(); tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("clr.pre_drop", 32'(drop_count_a), 5);
    chk("clr.pre_busy", 32'(busy_a),       1);
    #2 clear = 1'b0;
    #1;
    chk("clr.out_valid",  32'(out_valid_a),  0);
    chk("clr.out_data",   32'(out_data_a),   0);
    chk("clr.busy",       32'(busy_a),       0);
    chk("clr.overflow",   32'(overflow_a),   0);
    chk("clr.drop_count", 32'(drop_count_a), 0);
    chk("clr.b_drop",     32'(drop_count_b), 0);
    model_reset();
    tick();
    clear = 1'b1;
    tick();

    // Randomized traffic with bursty backpressure and rare clears.
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 23) == 0);
      if ($urandom_range(0, 3) == 0) qval    = ~qval;
      if ($urandom_range(0, 3) == 0) udp_out = ~udp_out;
      if ($urandom_range(0, 3) == 0) muxout  = ~muxout;
      if (((c / 64) % 2) == 0) out_ready = ($urandom_range(0, 3) == 0);
      else                     out_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
